// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard scoreboard: stall-cause codes and the
// hard-wired zero register index.
package hazard_pkg;

  typedef enum logic [1:0] {
    CAUSE_NONE      = 2'd0,
    CAUSE_LOAD      = 2'd1,
    CAUSE_MD_DATA   = 2'd2,
    CAUSE_MD_STRUCT = 2'd3
  } stall_cause_e;

  // x0 is never a real producer, so it is excluded from every match.
  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/hazard_tag_shift.sv
// Valid+tag shift register with a hold enable. Entry 0 takes the new tag;
// older entries move up by one place each enabled cycle.
module hazard_tag_shift #(
  parameter int DEPTH = 1,
  parameter int TAG_W = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        hold,
  input  logic                        in_v,
  input  logic [TAG_W-1:0]            in_tag,
  output logic [DEPTH-1:0]            v,
  output logic [DEPTH-1:0][TAG_W-1:0] tag
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: tags are cleared along with the valid bits so they never read as X
      // downstream; functionally only the valid bits need a reset.
      v   <= '0;
      tag <= '0;
    end else if (!hold) begin
      // NOTE: non-blocking assignments make every stage read the pre-edge value,
      // so the loop order does not matter and no entry is skipped.
      for (int k = DEPTH - 1; k > 0; k--) begin
        v[k]   <= v[k-1];
        tag[k] <= tag[k-1];
      end
      v[0]   <= in_v;
      tag[0] <= in_tag;
    end
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// ID-stage hazard unit: load-use window tracking, MUL/DIV latency scoreboard,
// and front-end freeze while data memory is not ready.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int LOAD_USE_GAP = 1,
  parameter int MD_LATENCY   = 4,
  parameter int MD_CNT_W     = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  id_is_md,
  input  logic                  ex_valid,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_is_md,
  input  logic                  ex_flush,
  input  logic                  dmem_ready,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  id_ex_bubble,
  output logic                  pipe_freeze,
  output logic                  md_busy,
  output logic [1:0]            stall_cause
);

  localparam logic [REG_ADDR_W-1:0] ZERO_IDX = REG_ADDR_W'(REG_ZERO);

  function automatic logic match(
    input logic [REG_ADDR_W-1:0] r,
    input logic [REG_ADDR_W-1:0] rs1,
    input logic [REG_ADDR_W-1:0] rs2,
    input logic                  use1,
    input logic                  use2
  );
    return (r != ZERO_IDX) && ((use1 && rs1 == r) || (use2 && rs2 == r));
  endfunction

  logic frozen;
  logic ex_ok;
  logic ex_live;
  logic lq_hit;

  assign frozen  = !dmem_ready;
  assign ex_ok   = ex_valid && !ex_flush;
  assign ex_live = ex_ok && (ex_rd != ZERO_IDX);

  // Loads that left EX but are still inside the load-use window.
  if (LOAD_USE_GAP > 1) begin : g_lq
    localparam int DEPTH = LOAD_USE_GAP - 1;

    logic [DEPTH-1:0]                 lq_v;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] lq_rd;

    hazard_tag_shift #(
      .DEPTH (DEPTH),
      .TAG_W (REG_ADDR_W)
    ) u_lq (
      .clk    (clk),
      .rst    (rst),
      .hold   (frozen),
      .in_v   (ex_live && ex_mem_read),
      .in_tag (ex_rd),
      .v      (lq_v),
      .tag    (lq_rd)
    );

    always_comb begin
      lq_hit = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        if (lq_v[k] && match(lq_rd[k], id_rs1, id_rs2, id_uses_rs1, id_uses_rs2)) begin
          lq_hit = 1'b1;
        end
      end
    end
  end else begin : g_no_lq
    assign lq_hit = 1'b0;
  end

  logic [MD_CNT_W-1:0]   md_cnt;
  logic [REG_ADDR_W-1:0] md_rd;
  logic                  md_active;
  logic                  md_issue;

  assign md_active = (md_cnt != '0);
  assign md_issue  = ex_ok && ex_is_md && !md_active && !frozen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      md_cnt <= '0;
      md_rd  <= '0;
    end else if (md_issue) begin
      md_cnt <= MD_CNT_W'(MD_LATENCY - 1);
      md_rd  <= ex_rd;
    end else if (md_active && !frozen) begin
      md_cnt <= md_cnt - 1'b1;
    end
  end

  logic load_stall;
  logic md_data_stall;
  logic md_struct_stall;

  assign load_stall = (ex_live && ex_mem_read &&
                       match(ex_rd, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2)) || lq_hit;

  // The op sitting in EX this cycle counts before it reaches the counter.
  assign md_data_stall =
      (md_active && match(md_rd, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2)) ||
      (ex_ok && ex_is_md && match(ex_rd, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2));

  assign md_struct_stall = id_is_md && (md_active || (ex_ok && ex_is_md));

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned
    // and infers a latch.
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    pipe_freeze  = frozen;
    md_busy      = md_active;
    stall_cause  = CAUSE_NONE;

    if (rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      pipe_freeze  = 1'b0;
      md_busy      = 1'b0;
    end else if (frozen) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else if (load_stall || md_data_stall || md_struct_stall) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      if (load_stall)         stall_cause = CAUSE_LOAD;
      else if (md_data_stall) stall_cause = CAUSE_MD_DATA;
      else                    stall_cause = CAUSE_MD_STRUCT;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: two instances (load-use gap 1 and 3) share
// stimulus; directed scenarios plus a randomized run against a timeline model.
module tb_hazard_scoreboard_unit;

  localparam int W   = 5;
  localparam int LAT = 4;

  // Output vector layout: {pc_write, if_id_write, id_ex_bubble, pipe_freeze, md_busy, stall_cause}
  localparam logic [6:0] RUN       = 7'b1100000;
  localparam logic [6:0] RUN_B     = 7'b1100100;
  localparam logic [6:0] STALL_L   = 7'b0010001;
  localparam logic [6:0] STALL_D   = 7'b0010010;
  localparam logic [6:0] STALL_D_B = 7'b0010110;
  localparam logic [6:0] STALL_S   = 7'b0010011;
  localparam logic [6:0] STALL_S_B = 7'b0010111;
  localparam logic [6:0] FROZE     = 7'b0001000;
  localparam logic [6:0] FROZE_B   = 7'b0001100;
  localparam logic [6:0] IN_RST    = 7'b0010000;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] id_rs1, id_rs2, ex_rd;
  logic         id_uses_rs1, id_uses_rs2, id_is_md;
  logic         ex_valid, ex_mem_read, ex_is_md, ex_flush, dmem_ready;

  logic       a_pc_write, a_if_id_write, a_id_ex_bubble, a_pipe_freeze, a_md_busy;
  logic [1:0] a_stall_cause;
  logic       b_pc_write, b_if_id_write, b_id_ex_bubble, b_pipe_freeze, b_md_busy;
  logic [1:0] b_stall_cause;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_unit #(
    .REG_ADDR_W(W), .LOAD_USE_GAP(1), .MD_LATENCY(LAT), .MD_CNT_W(5)
  ) dut_gap1 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_is_md(id_is_md),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_is_md(ex_is_md), .ex_flush(ex_flush), .dmem_ready(dmem_ready),
    .pc_write(a_pc_write), .if_id_write(a_if_id_write), .id_ex_bubble(a_id_ex_bubble),
    .pipe_freeze(a_pipe_freeze), .md_busy(a_md_busy), .stall_cause(a_stall_cause)
  );

  hazard_scoreboard_unit #(
    .REG_ADDR_W(W), .LOAD_USE_GAP(3), .MD_LATENCY(LAT), .MD_CNT_W(5)
  ) dut_gap3 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_is_md(id_is_md),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_is_md(ex_is_md), .ex_flush(ex_flush), .dmem_ready(dmem_ready),
    .pc_write(b_pc_write), .if_id_write(b_if_id_write), .id_ex_bubble(b_id_ex_bubble),
    .pipe_freeze(b_pipe_freeze), .md_busy(b_md_busy), .stall_cause(b_stall_cause)
  );

  wire [6:0] obs_a = {a_pc_write, a_if_id_write, a_id_ex_bubble, a_pipe_freeze, a_md_busy, a_stall_cause};
  wire [6:0] obs_b = {b_pc_write, b_if_id_write, b_id_ex_bubble, b_pipe_freeze, b_md_busy, b_stall_cause};

  // ---------------- stimulus helpers ----------------
  task automatic set_ex(input logic v, input logic [W-1:0] rd, input logic ld,
                        input logic md, input logic fl);
    ex_valid = v; ex_rd = rd; ex_mem_read = ld; ex_is_md = md; ex_flush = fl;
  endtask

  task automatic set_id(input logic [W-1:0] rs1, input logic u1, input logic [W-1:0] rs2,
                        input logic u2, input logic md);
    id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2; id_is_md = md;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic go_idle(input int n);
    set_ex(0, 0, 0, 0, 0);
    set_id(0, 0, 0, 0, 0);
    dmem_ready = 1'b1;
    repeat (n) next_cycle();
  endtask

  // ---------------- reference model: time-stamped history ----------------
  typedef struct {
    logic [W-1:0] rd;
    longint       t;
  } load_t;

  load_t        loads[$];
  longint       t_now   = 0;   // counts unfrozen clock edges
  longint       md_done = 0;   // first time at which the MUL/DIV result is available
  logic [W-1:0] md_tag  = '0;

  function automatic logic reads(input logic [W-1:0] r);
    return (r != 0) && ((id_uses_rs1 && id_rs1 == r) || (id_uses_rs2 && id_rs2 == r));
  endfunction

  function automatic logic [6:0] model_out(input int gap);
    logic ex_ok, busy, ld, mdd, mds;
    ex_ok = ex_valid && !ex_flush;
    busy  = t_now < md_done;
    ld    = ex_ok && ex_mem_read && reads(ex_rd);
    foreach (loads[i])
      if ((t_now - loads[i].t) < longint'(gap) && reads(loads[i].rd)) ld = 1'b1;
    mdd = (busy && reads(md_tag)) || (ex_ok && ex_is_md && reads(ex_rd));
    mds = id_is_md && (busy || (ex_ok && ex_is_md));
    if (rst)             return IN_RST;
    if (!dmem_ready)     return {5'b00010, 2'b00} | {4'b0, busy, 2'b00};
    if (ld)              return {4'b0010, busy, 2'd1};
    if (mdd)             return {4'b0010, busy, 2'd2};
    if (mds)             return {4'b0010, busy, 2'd3};
    return {4'b1100, busy, 2'd0};
  endfunction

  task automatic model_reset();
    loads.delete();
    md_done = t_now;
    md_tag  = '0;
  endtask

  task automatic model_clock();
    logic ex_ok;
    ex_ok = ex_valid && !ex_flush;
    if (rst || !dmem_ready) return;
    if (ex_ok && ex_is_md && !(t_now < md_done)) begin
      md_done = t_now + LAT;
      md_tag  = ex_rd;
    end
    if (ex_ok && ex_mem_read && ex_rd != 0) loads.push_back('{rd: ex_rd, t: t_now});
    t_now++;
    while (loads.size() > 0 && (t_now - loads[0].t) > 8) void'(loads.pop_front());
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    dmem_ready = 1'b0;
    set_ex(1, 5, 1, 1, 0);
    set_id(5, 1, 5, 1, 1);
    #1;
    checks++;
    if (obs_a !== IN_RST) begin failures++; $display("FAIL reset_gap1 got=%b want=%b", obs_a, IN_RST); end
    checks++;
    if (obs_b !== IN_RST) begin failures++; $display("FAIL reset_gap3 got=%b want=%b", obs_b, IN_RST); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    go_idle(0);
    #1;
    checks++;
    if (obs_a !== RUN) begin failures++; $display("FAIL post_reset_gap1 got=%b want=%b", obs_a, RUN); end
    checks++;
    if (obs_b !== RUN) begin failures++; $display("FAIL post_reset_gap3 got=%b want=%b", obs_b, RUN); end
    next_cycle();
  endtask

  task automatic test_load_use();
    logic [6:0] ea [7];
    logic [6:0] eb [7];
    ea = '{STALL_L, RUN, RUN, RUN, RUN, RUN, RUN};
    eb = '{STALL_L, STALL_L, STALL_L, RUN, RUN, RUN, RUN};
    for (int c = 0; c < 7; c++) begin
      // cycle 0: load x5 with reader of x5; cycle 4: load x0 with reader of x0
      set_ex(c == 0 || c == 4, (c == 4) ? 5'd0 : 5'd5, 1'b1, 1'b0, 1'b0);
      set_id((c < 4) ? 5'd5 : 5'd0, 1'b1, 5'd1, 1'b0, 1'b0);
      #1;
      checks++;
      if (obs_a !== ea[c]) begin failures++; $display("FAIL load_use_gap1 cyc=%0d got=%b want=%b", c, obs_a, ea[c]); end
      checks++;
      if (obs_b !== eb[c]) begin failures++; $display("FAIL load_use_gap3 cyc=%0d got=%b want=%b", c, obs_b, eb[c]); end
      next_cycle();
    end
    go_idle(6);
  endtask

  task automatic test_md();
    logic [6:0] e [10];
    e = '{STALL_D, STALL_D_B, STALL_D_B, STALL_D_B, RUN,
          STALL_S, STALL_S_B, STALL_S_B, STALL_S_B, RUN};
    for (int c = 0; c < 10; c++) begin
      set_ex(c == 0 || c == 5, 5'd9, 1'b0, 1'b1, 1'b0);
      if (c < 5) set_id(5'd2, 1'b1, 5'd9, 1'b1, 1'b0);
      else       set_id(5'd3, 1'b1, 5'd0, 1'b0, 1'b1);
      #1;
      checks++;
      if (obs_a !== e[c]) begin failures++; $display("FAIL md_gap1 cyc=%0d got=%b want=%b", c, obs_a, e[c]); end
      checks++;
      if (obs_b !== e[c]) begin failures++; $display("FAIL md_gap3 cyc=%0d got=%b want=%b", c, obs_b, e[c]); end
      next_cycle();
    end
    go_idle(6);
  endtask

  task automatic test_freeze();
    logic [6:0] e [13];
    logic       rdy [13];
    e   = '{RUN, RUN_B, FROZE_B, FROZE_B, STALL_D_B, STALL_D_B, RUN,
            FROZE, STALL_D, STALL_D_B, STALL_D_B, STALL_D_B, RUN};
    rdy = '{1, 1, 0, 0, 1, 1, 1, 0, 1, 1, 1, 1, 1};
    for (int c = 0; c < 13; c++) begin
      dmem_ready = rdy[c];
      if (c == 0)                set_ex(1, 5'd10, 0, 1, 0);
      else if (c == 7 || c == 8) set_ex(1, 5'd11, 0, 1, 0);  // issue deferred by freeze
      else                       set_ex(0, 5'd0, 0, 0, 0);
      if (c < 2)      set_id(5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      else if (c < 7) set_id(5'd10, 1'b1, 5'd0, 1'b0, 1'b0);
      else            set_id(5'd11, 1'b1, 5'd0, 1'b0, 1'b0);
      #1;
      checks++;
      if (obs_a !== e[c]) begin failures++; $display("FAIL freeze_gap1 cyc=%0d got=%b want=%b", c, obs_a, e[c]); end
      checks++;
      if (obs_b !== e[c]) begin failures++; $display("FAIL freeze_gap3 cyc=%0d got=%b want=%b", c, obs_b, e[c]); end
      next_cycle();
    end
    go_idle(6);
  endtask

  task automatic test_flush();
    for (int c = 0; c < 3; c++) begin
      set_ex(c == 0, 5'd4, 1'b1, 1'b0, c == 0);
      set_id(5'd4, 1'b1, 5'd4, 1'b1, 1'b0);
      #1;
      checks++;
      if (obs_a !== RUN) begin failures++; $display("FAIL flush_gap1 cyc=%0d got=%b want=%b", c, obs_a, RUN); end
      checks++;
      if (obs_b !== RUN) begin failures++; $display("FAIL flush_gap3 cyc=%0d got=%b want=%b", c, obs_b, RUN); end
      next_cycle();
    end
    go_idle(4);
  endtask

  task automatic test_reset_mid_md();
    set_ex(1, 5'd12, 0, 1, 0);
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    next_cycle();
    set_ex(0, 5'd0, 0, 0, 0);
    next_cycle();
    #1;
    checks++;
    if (obs_b !== RUN_B) begin failures++; $display("FAIL md_before_reset got=%b want=%b", obs_b, RUN_B); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs_a !== IN_RST) begin failures++; $display("FAIL mid_md_reset_gap1 got=%b want=%b", obs_a, IN_RST); end
    checks++;
    if (obs_b !== IN_RST) begin failures++; $display("FAIL mid_md_reset_gap3 got=%b want=%b", obs_b, IN_RST); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      set_id(5'd12, 1'b1, 5'd12, 1'b1, 1'b0);
      #1;
      checks++;
      if (obs_a !== RUN) begin failures++; $display("FAIL after_reset_gap1 cyc=%0d got=%b want=%b", c, obs_a, RUN); end
      checks++;
      if (obs_b !== RUN) begin failures++; $display("FAIL after_reset_gap3 cyc=%0d got=%b want=%b", c, obs_b, RUN); end
      next_cycle();
    end
    go_idle(2);
  endtask

  task automatic test_random();
    logic [6:0] ea, eb;
    model_reset();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      if (rst) model_reset();
      set_ex($urandom_range(0, 3) != 0, W'($urandom_range(0, 3)), $urandom_range(0, 2) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
      set_id(W'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, W'($urandom_range(0, 3)),
             $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
      dmem_ready = ($urandom_range(0, 5) != 0);
      #1;
      ea = model_out(1);
      eb = model_out(3);
      checks++;
      if (obs_a !== ea) begin failures++; $display("FAIL random_gap1 cyc=%0d got=%b want=%b", c, obs_a, ea); end
      checks++;
      if (obs_b !== eb) begin failures++; $display("FAIL random_gap3 cyc=%0d got=%b want=%b", c, obs_b, eb); end
      @(posedge clk);
      model_clock();
      @(negedge clk);
    end
    rst = 1'b0;
    go_idle(2);
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_md();
    test_freeze();
    test_flush();
    test_reset_mid_md();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule
